// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter between the ADS1292 sample stream and the
//   MPR121 touch stream. A source is granted for a whole packet. Each packet is
//   prefixed with a source-ID header byte, every byte is paced against the
//   UART busy flag, and priority rotates round-robin between packets. A
//   per-byte watchdog aborts a packet whose source stalls inside it.
//
// Ports
//   i_CLK, i_RSTN                      clock, asynchronous active-low reset
//   i_ADS_VALID/i_ADS_DATA/i_ADS_LAST  ADS1292 byte stream
//   o_ADS_READY                        ADS1292 byte accepted (with VALID)
//   i_MPR_VALID/i_MPR_DATA/i_MPR_LAST  MPR121 byte stream
//   o_MPR_READY                        MPR121 byte accepted (with VALID)
//   o_TX_DATA, o_TX_START              byte and start pulse to the UART core
//   i_TX_BUSY                          UART core busy
//   o_GRANT                            one-hot grant {MPR121, ADS1292}
//   o_TIMEOUT_ERR                      one-cycle pulse on packet abort
//   o_ERR_CNT                          saturating abort count
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter logic [7:0]  HDR_ADS = 8'hA5,
  parameter logic [7:0]  HDR_MPR = 8'hB5,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       i_CLK,
  input  logic       i_RSTN,
  input  logic       i_ADS_VALID,
  input  logic [7:0] i_ADS_DATA,
  input  logic       i_ADS_LAST,
  output logic       o_ADS_READY,
  input  logic       i_MPR_VALID,
  input  logic [7:0] i_MPR_DATA,
  input  logic       i_MPR_LAST,
  output logic       o_MPR_READY,
  output logic [7:0] o_TX_DATA,
  output logic       o_TX_START,
  input  logic       i_TX_BUSY,
  output logic [1:0] o_GRANT,
  output logic       o_TIMEOUT_ERR,
  output logic [7:0] o_ERR_CNT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_HDR,
    S_FETCH,
    S_WAIT_DATA
  } state_t;

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);
  localparam logic        SRC_ADS  = 1'b0;
  localparam logic        SRC_MPR  = 1'b1;

  state_t      r_state;
  state_t      w_next;

  logic        r_guard;      // first cycle after a start: busy may not be up yet
  logic        r_src;        // source owning the current packet
  logic        r_last_src;   // last served source, for round-robin
  logic        r_pkt_last;   // byte in flight closes the packet
  logic [15:0] r_wd;         // FETCH cycles spent with VALID low
  logic [1:0]  r_grant;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;
  logic        r_to_err;
  logic [7:0]  r_err_cnt;

  logic        w_any_req;
  logic        w_pick;
  logic        w_start_hdr;
  logic        w_g_valid;
  logic [7:0]  w_g_data;
  logic        w_g_last;
  logic        w_fetch_rdy;
  logic        w_hs;
  logic        w_link_free;
  logic        w_abort;
  logic        w_pkt_done;

  // ---------------------------------------------------------------------------
  // Request selection and granted-source muxing
  // ---------------------------------------------------------------------------
  always_comb begin
    w_any_req = i_ADS_VALID | i_MPR_VALID;
    // On a tie serve the source that did not go last; otherwise the requester.
    if (i_ADS_VALID && i_MPR_VALID) begin
      w_pick = ~r_last_src;
    end else begin
      w_pick = i_MPR_VALID ? SRC_MPR : SRC_ADS;
    end

    if (r_src == SRC_MPR) begin
      w_g_valid = i_MPR_VALID;
      w_g_data  = i_MPR_DATA;
      w_g_last  = i_MPR_LAST;
    end else begin
      w_g_valid = i_ADS_VALID;
      w_g_data  = i_ADS_DATA;
      w_g_last  = i_ADS_LAST;
    end
  end

  always_comb begin
    w_start_hdr = (r_state == S_IDLE) && w_any_req && !i_TX_BUSY;
    w_fetch_rdy = (r_state == S_FETCH) && !i_TX_BUSY;
    w_hs        = w_fetch_rdy && w_g_valid;
    w_link_free = !r_guard && !i_TX_BUSY;
    w_abort     = (r_state == S_FETCH) && !w_g_valid && (r_wd == WD_LIMIT);
    w_pkt_done  = ((r_state == S_WAIT_DATA) && w_link_free && r_pkt_last) || w_abort;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_hdr) w_next = S_WAIT_HDR;
      end
      S_WAIT_HDR: begin
        if (w_link_free) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (w_hs) begin
          w_next = S_WAIT_DATA;
        end else if (w_abort) begin
          w_next = S_IDLE;
        end
      end
      S_WAIT_DATA: begin
        if (w_link_free) w_next = r_pkt_last ? S_IDLE : S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (READY is combinational so a byte is taken the cycle it shows)
  // ---------------------------------------------------------------------------
  always_comb begin
    o_ADS_READY = w_fetch_rdy && r_grant[0];
    o_MPR_READY = w_fetch_rdy && r_grant[1];
  end

  // ---------------------------------------------------------------------------
  // Datapath: grant, TX byte/start, watchdog and error counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      r_guard    <= 1'b0;
      r_src      <= SRC_ADS;
      r_last_src <= SRC_MPR;
      r_pkt_last <= 1'b0;
      r_wd       <= '0;
      r_grant    <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_to_err   <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_tx_start <= w_start_hdr || w_hs;
      r_guard    <= w_start_hdr || w_hs;
      r_to_err   <= w_abort;

      if (w_start_hdr) begin
        r_src      <= w_pick;
        r_grant    <= (w_pick == SRC_MPR) ? 2'b10 : 2'b01;
        r_tx_data  <= (w_pick == SRC_MPR) ? HDR_MPR : HDR_ADS;
        r_pkt_last <= 1'b0;
      end else if (w_hs) begin
        r_tx_data  <= w_g_data;
        r_pkt_last <= w_g_last;
      end

      if (w_pkt_done) begin
        r_grant    <= '0;
        r_last_src <= r_src;
      end

      // Held at zero outside FETCH, so every FETCH entry starts a fresh count.
      if (r_state != S_FETCH) begin
        r_wd <= '0;
      end else if (!w_g_valid && !w_abort) begin
        r_wd <= r_wd + 16'd1;
      end

      if (w_abort && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign o_TX_DATA     = r_tx_data;
  assign o_TX_START    = r_tx_start;
  assign o_GRANT       = r_grant;
  assign o_TIMEOUT_ERR = r_to_err;
  assign o_ERR_CNT     = r_err_cnt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Drives both byte streams from packet queues, emulates the UART core busy
//   flag, and checks every cycle against a link-level reference model, plus
//   directed scenarios with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int          TOUT    = 20;
  localparam logic [7:0]  H_ADS   = 8'hA5;
  localparam logic [7:0]  H_MPR   = 8'hB5;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [7:0] gap;   // cycles VALID stays low before this byte is shown
  } item_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] vld;
  logic [7:0] dat [2];
  logic [1:0] lst;
  logic       busy;
  logic       o_ADS_READY, o_MPR_READY, o_TX_START, o_TIMEOUT_ERR;
  logic [7:0] o_TX_DATA, o_ERR_CNT;
  logic [1:0] o_GRANT;

  uart_tx_arbiter #(
    .HDR_ADS (H_ADS),
    .HDR_MPR (H_MPR),
    .TIMEOUT (TOUT)
  ) dut (
    .i_CLK         (clk),
    .i_RSTN        (rst_n),
    .i_ADS_VALID   (vld[0]),
    .i_ADS_DATA    (dat[0]),
    .i_ADS_LAST    (lst[0]),
    .o_ADS_READY   (o_ADS_READY),
    .i_MPR_VALID   (vld[1]),
    .i_MPR_DATA    (dat[1]),
    .i_MPR_LAST    (lst[1]),
    .o_MPR_READY   (o_MPR_READY),
    .o_TX_DATA     (o_TX_DATA),
    .o_TX_START    (o_TX_START),
    .i_TX_BUSY     (busy),
    .o_GRANT       (o_GRANT),
    .o_TIMEOUT_ERR (o_TIMEOUT_ERR),
    .o_ERR_CNT     (o_ERR_CNT)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus state shared with drivers
  // ---------------------------------------------------------------------------
  item_t      qa[$];
  item_t      qm[$];
  int         hs_cnt[2];
  logic [7:0] tx_log[$];
  int         tx_len;
  bit         rand_len;
  bit         force_busy;

  int cyc, start_cnt, ready_cnt, mpr_ready_cnt, err_pulses, mpr_rise_cyc, err_gap;
  bit prev_mpr_rdy;

  // ---------------------------------------------------------------------------
  // Reference model: tracks the link (byte in flight / waiting for a byte) and
  // who owns it, derived from the observed inputs of each cycle.
  // ---------------------------------------------------------------------------
  int         m_g;       // owner of the link: -1 none, 0 ADS1292, 1 MPR121
  int         m_last;    // last served source
  bit         m_fly;     // a byte has been started and the link is not yet free
  bit         m_fresh;   // current cycle is the start cycle of that byte
  bit         m_plast;   // byte in flight ends the packet
  bit         m_fetch;   // link free, waiting for the owner's next byte
  int         m_wd;      // waiting cycles with VALID low so far
  logic [7:0] e_data;
  bit         e_start, e_err;
  int         e_cnt;
  logic [1:0] e_grant;

  task automatic model_reset();
    m_g = -1; m_last = 1; m_fly = 0; m_fresh = 0; m_plast = 0; m_fetch = 0;
    m_wd = 0; e_data = 8'h00; e_start = 0; e_err = 0; e_cnt = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) model_reset();
    e_grant = (m_g < 0) ? 2'b00 : ((m_g == 0) ? 2'b01 : 2'b10);
    chk("grant",       o_GRANT,       e_grant);
    chk("tx_start",    o_TX_START,    e_start);
    chk("tx_data",     o_TX_DATA,     e_data);
    chk("ads_ready",   o_ADS_READY,   (m_g == 0) && m_fetch && !busy);
    chk("mpr_ready",   o_MPR_READY,   (m_g == 1) && m_fetch && !busy);
    chk("timeout_err", o_TIMEOUT_ERR, e_err);
    chk("err_cnt",     o_ERR_CNT,     e_cnt);

    if (rst_n) begin
      if (o_ADS_READY && vld[0]) hs_cnt[0]++;
      if (o_MPR_READY && vld[1]) hs_cnt[1]++;
      if (o_TX_START) begin
        tx_log.push_back(o_TX_DATA);
        start_cnt++;
      end
      if (o_ADS_READY || o_MPR_READY) ready_cnt++;
      if (o_MPR_READY) mpr_ready_cnt++;
      if (o_MPR_READY && !prev_mpr_rdy) mpr_rise_cyc = cyc;
      prev_mpr_rdy = o_MPR_READY;
      if (o_TIMEOUT_ERR) begin
        err_pulses++;
        err_gap = cyc - mpr_rise_cyc;
      end

      e_start = 0;
      e_err   = 0;
      if (m_g < 0) begin
        if ((vld[0] || vld[1]) && !busy) begin
          if (vld[0] && vld[1]) m_g = 1 - m_last;
          else                  m_g = vld[0] ? 0 : 1;
          e_data  = (m_g == 0) ? H_ADS : H_MPR;
          e_start = 1; m_fly = 1; m_fresh = 1; m_plast = 0;
        end
      end else if (m_fly) begin
        if (m_fresh) begin
          m_fresh = 0;
        end else if (!busy) begin
          m_fly = 0;
          if (m_plast) begin
            m_last = m_g; m_g = -1;
          end else begin
            m_fetch = 1; m_wd = 0;
          end
        end
      end else if (m_fetch) begin
        if (vld[m_g] && !busy) begin
          e_data  = dat[m_g];
          e_start = 1; m_fly = 1; m_fresh = 1; m_plast = lst[m_g]; m_fetch = 0;
        end else if (!vld[m_g]) begin
          if (m_wd == TOUT - 1) begin
            e_err = 1;
            if (e_cnt < 255) e_cnt++;
            m_last = m_g; m_g = -1; m_fetch = 0;
          end else begin
            m_wd++;
          end
        end
      end
    end else begin
      prev_mpr_rdy = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Source drivers: present queue heads, pop on observed handshakes
  // ---------------------------------------------------------------------------
  task automatic drive(input int s);
    bit    loaded;
    int    gap;
    int    seen;
    item_t it;
    loaded = 0; gap = 0; seen = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        vld[s] = 1'b0; loaded = 0; seen = hs_cnt[s];
      end else begin
        if (hs_cnt[s] != seen) begin
          seen = hs_cnt[s];
          if (s == 0 && qa.size() > 0) qa.delete(0);
          if (s == 1 && qm.size() > 0) qm.delete(0);
          loaded = 0; vld[s] = 1'b0;
        end
        if (((s == 0) ? qa.size() : qm.size()) == 0) begin
          loaded = 0; vld[s] = 1'b0;
        end else begin
          it = (s == 0) ? qa[0] : qm[0];
          if (!loaded) begin
            gap = int'(it.gap); loaded = 1;
          end
          if (gap > 0) begin
            gap--; vld[s] = 1'b0;
          end else begin
            vld[s] = 1'b1; dat[s] = it.d; lst[s] = it.l;
          end
        end
      end
    end
  endtask

  // UART core: busy for tx_len cycles starting the cycle after each start.
  task automatic tx_core();
    int  bcnt;
    bit  bnow;
    bcnt = 0;
    forever begin
      @(posedge clk); #2;
      bnow = (bcnt > 0);
      if (bcnt > 0) bcnt--;
      if (o_TX_START) bcnt = rand_len ? $urandom_range(1, 6) : tx_len;
      busy = force_busy | bnow;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic bit drained();
    return qa.size() == 0 && qm.size() == 0 && vld == 2'b00 && o_GRANT == 2'b00;
  endfunction

  task automatic wait_drain(input string nm, input int budget);
    int k;
    k = 0;
    step();
    while (k < budget && !drained()) begin
      step(); k++;
    end
    chk(nm, k < budget, 1);
    repeat (3) step();
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic l, input logic [7:0] g);
    item_t it;
    it.d = d; it.l = l; it.gap = g;
    if (s == 0) qa.push_back(it);
    else        qm.push_back(it);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    qa.delete(); qm.delete();
    force_busy = 0;
    repeat (3) step();
    tx_log.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic chk_log(input string nm, input logic [7:0] exp [], input int n);
    chk({nm, "_len"}, tx_log.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < tx_log.size()) chk($sformatf("%s[%0d]", nm, i), tx_log[i], exp[i]);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_grant"}, o_GRANT, 2'b00);
    chk({nm, "_data"},  o_TX_DATA, 8'h00);
    chk({nm, "_start"}, o_TX_START, 1'b0);
    chk({nm, "_ardy"},  o_ADS_READY, 1'b0);
    chk({nm, "_mrdy"},  o_MPR_READY, 1'b0);
    chk({nm, "_terr"},  o_TIMEOUT_ERR, 1'b0);
    chk({nm, "_ecnt"},  o_ERR_CNT, 8'h00);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] exp [];
    int         k, lat, ep0, s0, r0, m0, hs0, pushed, s, n;
    item_t      it;

    rst_n = 1'b0; vld = 2'b00; lst = 2'b00; dat[0] = 8'h00; dat[1] = 8'h00;
    busy = 1'b0; tx_len = 3; rand_len = 0; force_busy = 0;
    hs_cnt[0] = 0; hs_cnt[1] = 0;
    fork
      drive(0);
      drive(1);
      tx_core();
    join_none

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    chk_reset_outputs("reset");

    // Single ADS1292 packet, 10-cycle busy per byte
    tx_len = 10;
    m0 = mpr_ready_cnt;
    push(0, 8'h11, 0, 0); push(0, 8'h22, 0, 0); push(0, 8'h33, 1, 0);
    wait_drain("single_drain", 500);
    exp = new[4]; exp[0] = 8'hA5; exp[1] = 8'h11; exp[2] = 8'h22; exp[3] = 8'h33;
    chk_log("single", exp, 4);
    chk("single_mpr_ready", mpr_ready_cnt - m0, 0);

    // Simultaneous requests from reset, round-robin
    do_reset();
    tx_len = 3;
    push(0, 8'h01, 0, 0); push(0, 8'h02, 1, 0); push(0, 8'h05, 0, 0); push(0, 8'h06, 1, 0);
    push(1, 8'h03, 0, 0); push(1, 8'h04, 1, 0);
    wait_drain("rr_drain", 500);
    exp = new[9];
    exp[0] = 8'hA5; exp[1] = 8'h01; exp[2] = 8'h02; exp[3] = 8'hB5; exp[4] = 8'h03;
    exp[5] = 8'h04; exp[6] = 8'hA5; exp[7] = 8'h05; exp[8] = 8'h06;
    chk_log("rr", exp, 9);

    // Back-pressure: busy held high with both sources requesting
    do_reset();
    step();
    force_busy = 1;
    push(0, 8'h51, 1, 0); push(1, 8'h61, 1, 0);
    s0 = start_cnt; r0 = ready_cnt;
    repeat (100) step();
    chk("bp_starts", start_cnt - s0, 0);
    chk("bp_ready",  ready_cnt - r0, 0);
    chk("bp_grant",  o_GRANT, 2'b00);
    force_busy = 0;
    @(negedge clk);              // first cycle with busy low
    lat = 0;
    while (!o_TX_START && lat < 10) begin
      @(negedge clk); lat++;
    end
    chk("bp_latency", lat, 1);
    chk("bp_hdr",     o_TX_DATA, 8'hA5);
    chk("bp_hgrant",  o_GRANT, 2'b01);
    wait_drain("bp_drain", 500);

    // Watchdog: MPR121 stalls after one byte while ADS1292 waits
    do_reset();
    tx_len = 2;
    ep0 = err_pulses;
    push(1, 8'h77, 0, 0); push(1, 8'h78, 1, 40);
    k = 0;
    while (o_GRANT != 2'b10 && k < 200) begin step(); k++; end
    chk("wd_mpr_grant", o_GRANT, 2'b10);
    push(0, 8'h99, 1, 0);
    k = 0;
    while (err_pulses == ep0 && k < 200) begin step(); k++; end
    chk("wd_abort_seen", err_pulses - ep0, 1);
    chk("wd_abort_delay", err_gap, TOUT);
    chk("wd_err_cnt", o_ERR_CNT, 8'd1);
    k = 0;
    while (o_GRANT == 2'b00 && k < 200) begin step(); k++; end
    chk("wd_next_grant", o_GRANT, 2'b01);
    wait_drain("wd_drain", 500);
    exp = new[6];
    exp[0] = 8'hB5; exp[1] = 8'h77; exp[2] = 8'hA5; exp[3] = 8'h99; exp[4] = 8'hB5; exp[5] = 8'h78;
    chk_log("wd", exp, 6);

    // 300 more aborts: counter saturates
    for (int i = 0; i < 300; i++) push(1, 8'(i), 0, 40);
    push(1, 8'hEE, 1, 40);
    wait_drain("sat_drain", 30000);
    chk("sat_err_cnt", o_ERR_CNT, 8'd255);
    chk("sat_pulses", err_pulses - ep0, 301);

    // Reset during WAIT_DATA of byte 2
    tx_len = 10;
    tx_log.delete();
    push(0, 8'h01, 0, 0); push(0, 8'h02, 0, 0); push(0, 8'h03, 1, 0);
    k = 0;
    while (tx_log.size() < 3 && k < 200) begin step(); k++; end
    chk("mid_reached", tx_log.size(), 3);
    repeat (2) step();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    qa.delete(); qm.delete();
    repeat (3) step();
    tx_log.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    tx_len = 3;
    push(0, 8'h31, 1, 0); push(1, 8'h41, 1, 0);
    wait_drain("post_drain", 500);
    exp = new[4]; exp[0] = 8'hA5; exp[1] = 8'h31; exp[2] = 8'hB5; exp[3] = 8'h41;
    chk_log("post", exp, 4);

    // Randomized traffic against the reference model
    rand_len = 1;
    pushed = 0;
    hs0 = hs_cnt[0] + hs_cnt[1];
    for (int p = 0; p < 60; p++) begin
      s = $urandom_range(0, 1);
      n = $urandom_range(1, 4);
      for (int b = 0; b < n; b++) begin
        it.d = 8'($urandom);
        it.l = (b == n - 1);
        if (b == 0)                         it.gap = 8'($urandom_range(0, 6));
        else if ($urandom_range(0, 14) == 0) it.gap = 8'd35;
        else                                it.gap = 8'($urandom_range(0, 3));
        push(s, it.d, it.l, it.gap);
        pushed++;
      end
    end
    k = 0;
    step();
    while (k < 40000 && !drained()) begin
      step(); k++;
      if ($urandom_range(0, 31) == 0)      force_busy = 1;
      else if ($urandom_range(0, 3) == 0)  force_busy = 0;
    end
    force_busy = 0;
    chk("rand_drain", k < 40000, 1);
    repeat (20) step();
    chk("rand_bytes", hs_cnt[0] + hs_cnt[1] - hs0, pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
